// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back source select encoding.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_t;

endpackage

// File: rtl/wb_regfile_reg_array.sv
// Register storage: REG_NUM x DATA_W, one write port, two asynchronous read ports.
// x0 is never written and always reads as zero; contents clear on async active-low reset.
module reg_array
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [REG_NUM];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The zero gate on the read side keeps x0 at zero even if a write to it slips through.
    always_comb begin
        rdata1_o = (raddr1_i == REG_ZERO) ? '0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == REG_ZERO) ? '0 : mem_q[raddr2_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the WB value, commits it to the register file and counts commits.
// Optional REGFILE_BYPASS_EN makes ID reads see the value being written in the same cycle.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              RegWrite_i,
    input  logic              MemReg_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_we_o,
    output logic [31:0]       wb_count_o
);

    wb_sel_t           wb_sel;
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] arr_rdata1;
    logic [DATA_W-1:0] arr_rdata2;
    logic [31:0]       count_q;
    logic [31:0]       count_d;

    assign wb_sel  = wb_sel_t'(MemReg_i);
    assign wb_data = (wb_sel == WB_MEM) ? data2_i : data1_i;
    assign wb_we   = start_i & RegWrite_i & (rd_addr_i != REG_ZERO);

    reg_array u_reg_array (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .we_i     (wb_we),
        .waddr_i  (rd_addr_i),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr_i),
        .raddr2_i (rs2_addr_i),
        .rdata1_o (arr_rdata1),
        .rdata2_o (arr_rdata2)
    );

`ifdef REGFILE_BYPASS_EN
    // wb_we already excludes rd == x0, so a bypass hit never exposes data on address 0.
    always_comb begin
        rs1_data_o = arr_rdata1;
        rs2_data_o = arr_rdata2;
        if (wb_we && (rs1_addr_i == rd_addr_i)) begin
            rs1_data_o = wb_data;
        end
        if (wb_we && (rs2_addr_i == rd_addr_i)) begin
            rs2_data_o = wb_data;
        end
    end
`else
    assign rs1_data_o = arr_rdata1;
    assign rs2_data_o = arr_rdata2;
`endif

    // Counter wraps naturally at 32 bits.
    always_comb begin
        count_d = count_q;
        if (wb_we) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wb_data_o  = wb_data;
    assign wb_we_o    = wb_we;
    assign wb_count_o = count_q;

endmodule
